// File: rtl/forest_vote_engine_pkg.sv
// Shared types and sizing helpers for the forest vote engine.
package forest_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    ACCUM,
    SELECT,
    OUT
  } vote_state_t;

  typedef enum logic {
    VOTE_CLASS = 1'b0,
    VOTE_REG   = 1'b1
  } vote_mode_t;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/forest_vote_engine_if.sv
// Start/result handshake and tree-engine inputs of the forest vote engine.
interface forest_vote_engine_if
  import forest_pkg::*;
#(
  parameter int N_TREES = 16,
  parameter int LEAF_W  = 16,
  parameter int OUT_W   = 32
) ();
  localparam int CNT_W = cnt_w(N_TREES);

  logic                      start;
  logic                      start_ready;
  logic                      mode;
  logic [4:0]                shift;
  logic [CNT_W-1:0]          n_active;
  logic [N_TREES-1:0]        tree_done;
  logic [N_TREES*LEAF_W-1:0] leaf_vals;
  logic                      res_valid;
  logic                      res_ready;
  logic [OUT_W-1:0]          prediction;
  logic [CNT_W-1:0]          win_count;
  logic                      err;

  modport master (
    output start, mode, shift, n_active, tree_done, leaf_vals, res_ready,
    input  start_ready, res_valid, prediction, win_count, err
  );

  modport slave (
    input  start, mode, shift, n_active, tree_done, leaf_vals, res_ready,
    output start_ready, res_valid, prediction, win_count, err
  );
endinterface

// File: rtl/forest_vote_engine_argmax_scan.sv
// Sequential argmax over the vote bins, one bin per enabled cycle from index 0.
module forest_argmax_scan
  import forest_pkg::*;
#(
  parameter int N_TREES   = 16,
  parameter int N_CLASSES = 8,
  localparam int CNT_W    = cnt_w(N_TREES),
  localparam int IDX_W    = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       scan_en,
  input  logic [N_CLASSES*CNT_W-1:0] bins_flat,
  output logic                       scan_last,
  output logic [IDX_W-1:0]           win_idx,
  output logic [CNT_W-1:0]           win_cnt
);
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] win_idx_reg;
  logic [CNT_W-1:0] win_cnt_reg;
  logic [CNT_W-1:0] cur_bin;

  assign cur_bin   = bins_flat[int'(idx_reg)*CNT_W +: CNT_W];
  assign scan_last = (idx_reg == IDX_W'(N_CLASSES - 1));
  assign win_idx   = win_idx_reg;
  assign win_cnt   = win_cnt_reg;

  // Strict > keeps the earliest bin on ties; empty bins never displace index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg     <= '0;
      win_idx_reg <= '0;
      win_cnt_reg <= '0;
    end else if (clear) begin
      idx_reg     <= '0;
      win_idx_reg <= '0;
      win_cnt_reg <= '0;
    end else if (scan_en) begin
      if (cur_bin > win_cnt_reg) begin
        win_idx_reg <= idx_reg;
        win_cnt_reg <= cur_bin;
      end
      idx_reg <= scan_last ? '0 : idx_reg + IDX_W'(1);
    end
  end
endmodule

// File: rtl/forest_vote_engine.sv
// Ensemble aggregation: majority vote or shifted signed sum over the active trees,
// accumulated LANES trees per cycle and returned on a valid/ready handshake.
module forest_vote_engine
  import forest_pkg::*;
#(
  parameter int N_TREES   = 16,
  parameter int N_CLASSES = 8,
  parameter int LEAF_W    = 16,
  parameter int LANES     = 4,
  parameter int OUT_W     = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  forest_vote_engine_if.slave bus
);
  localparam int CNT_W  = cnt_w(N_TREES);
  localparam int SUM_W  = LEAF_W + $clog2(N_TREES);
  localparam int G      = N_TREES / LANES;
  localparam int GRP_W  = (G > 1) ? $clog2(G) : 1;
  localparam int TIDX_W = $clog2(N_TREES);
  localparam int IDX_W  = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;

  vote_state_t               state_reg, state_next;
  vote_mode_t                mode_reg;
  logic [4:0]                shift_reg;
  logic [CNT_W-1:0]          n_active_reg;
  logic [GRP_W-1:0]          grp_reg;
  logic [CNT_W-1:0]          bins_reg  [N_CLASSES];
  logic [CNT_W-1:0]          bins_next [N_CLASSES];
  logic signed [SUM_W-1:0]   sum_reg, sum_next;
  logic                      err_reg, err_next;
  logic [OUT_W-1:0]          reg_pred_reg;
  logic [N_TREES-1:0]        active_mask;
  logic [LEAF_W-1:0]         lane_leaf [LANES];
  logic [LANES-1:0]          lane_act;
  logic [N_CLASSES*CNT_W-1:0] bins_flat;
  logic                      accept, all_done, scan_en, scan_last;
  logic                      start_ready, res_valid;
  logic [IDX_W-1:0]          win_idx;
  logic [CNT_W-1:0]          win_cnt;

  assign accept   = (state_reg == IDLE) && bus.start;
  assign all_done = &(bus.tree_done | ~active_mask);

  for (genvar gi = 0; gi < N_TREES; gi++) begin : g_mask
    assign active_mask[gi] = (CNT_W'(gi) < n_active_reg);
  end

  // Lane gi of the current group sees tree grp*LANES + gi.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [TIDX_W-1:0] tree_idx;
    assign tree_idx      = TIDX_W'(grp_reg) * TIDX_W'(LANES) + TIDX_W'(gi);
    assign lane_leaf[gi] = bus.leaf_vals[int'(tree_idx)*LEAF_W +: LEAF_W];
    assign lane_act[gi]  = active_mask[tree_idx];
  end

  for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_flat
    assign bins_flat[gi*CNT_W +: CNT_W] = bins_reg[gi];
  end

  // Lanes are folded in order so several lanes voting for one bin all count.
  always_comb begin
    sum_next = sum_reg;
    err_next = err_reg;
    for (int c = 0; c < N_CLASSES; c++) bins_next[c] = bins_reg[c];
    for (int l = 0; l < LANES; l++) begin
      if (lane_act[l]) begin
        if (mode_reg == VOTE_REG) begin
          sum_next = sum_next + SUM_W'($signed(lane_leaf[l]));
        end else if (lane_leaf[l] < LEAF_W'(N_CLASSES)) begin
          bins_next[lane_leaf[l][IDX_W-1:0]] = bins_next[lane_leaf[l][IDX_W-1:0]] + CNT_W'(1);
        end else begin
          err_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mode_reg     <= VOTE_CLASS;
      shift_reg    <= '0;
      n_active_reg <= '0;
      grp_reg      <= '0;
      sum_reg      <= '0;
      err_reg      <= 1'b0;
      reg_pred_reg <= '0;
      for (int c = 0; c < N_CLASSES; c++) bins_reg[c] <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mode_reg     <= vote_mode_t'(bus.mode);
        shift_reg    <= bus.shift;
        n_active_reg <= bus.n_active;
        grp_reg      <= '0;
        sum_reg      <= '0;
        err_reg      <= 1'b0;
        reg_pred_reg <= '0;
        for (int c = 0; c < N_CLASSES; c++) bins_reg[c] <= '0;
      end else if (state_reg == ACCUM) begin
        grp_reg  <= grp_reg + GRP_W'(1);
        sum_reg  <= sum_next;
        err_reg  <= err_next;
        bins_reg <= bins_next;
      end else if (state_reg == SELECT && mode_reg == VOTE_REG) begin
        reg_pred_reg <= OUT_W'(sum_reg >>> shift_reg);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    scan_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        start_ready = 1'b1;
        if (bus.start) state_next = ARM;
      end
      ARM:   state_next = WAIT;
      WAIT:  if (all_done) state_next = ACCUM;
      ACCUM: if (grp_reg == GRP_W'(G - 1)) state_next = SELECT;
      SELECT: begin
        scan_en = (mode_reg == VOTE_CLASS);
        if (mode_reg == VOTE_REG || scan_last) state_next = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  forest_argmax_scan #(
    .N_TREES   (N_TREES),
    .N_CLASSES (N_CLASSES)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .scan_en   (scan_en),
    .bins_flat (bins_flat),
    .scan_last (scan_last),
    .win_idx   (win_idx),
    .win_cnt   (win_cnt)
  );

  assign bus.start_ready = start_ready;
  assign bus.res_valid   = res_valid;
  assign bus.prediction  = (mode_reg == VOTE_CLASS) ? OUT_W'(win_idx) : reg_pred_reg;
  assign bus.win_count   = (mode_reg == VOTE_CLASS) ? win_cnt : '0;
  assign bus.err         = err_reg;
endmodule
